seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 3-digit seven-segment display. It generates the one-hot digit select `sel` (001/010/100) that drives the 3:1 7-bit segment mux. It also generates the matching active-low anode enables `an_n`. Each digit is lit for one refresh period, with a programmable dead time at the start of each period to suppress ghosting.

Parameters:
CLK_DIV, 50000, clk cycles per digit dwell; legal range 2..65535.
CNT_W, 16, prescaler counter width; must satisfy 2^CNT_W >= CLK_DIV.
DEAD_CYC, 4, cycles at the start of each dwell with all anodes off; must be < CLK_DIV.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  scan enable; low freezes the scan and blanks the display.
blank_in  input  3  per-digit blank, bit i = digit i (bit 0 = sel 001).
sel  output  3  one-hot digit select to the segment mux, registered.
an_n  output  3  active-low anode enables, registered.
tick  output  1  one-cycle pulse on the cycle `sel` advances, registered.

Behaviour:
- Clock and reset: one clock `clk`. Reset is asynchronous, active-low, on `rst_n`, asserted asynchronously and released synchronously upstream.
- Reset values: prescaler cnt=0, sel=3'b001, an_n=3'b111, tick=0, dead counter=0.
- Prescaler: when en=1, cnt increments each cycle. At cnt==CLK_DIV-1 it wraps to 0, and the registered tick=1 on the following cycle.
- Select advance: on the wrap, sel rotates 001->010->100->001, landing in the same cycle tick is asserted.
- Illegal sel: any non-one-hot sel value, e.g. from an SEU, loads 001 on the next clock regardless of tick.
- Dead time: the dead counter reloads to DEAD_CYC on each sel change.
  - While the counter is nonzero, an_n=111 and the counter decrements.
  - When it reaches 0, an_n = ~(sel & ~blank_in), registered, so a blank_in change takes effect one cycle later.
  - With DEAD_CYC=0, the anode follows the new sel in the same cycle.
- en=0:
  - cnt, sel and the dead counter hold.
  - tick=0, and an_n=111 on the next clock.
  - When en returns to 1, counting resumes from the held cnt, and the anode re-enables on the next clock without a new dead period.
- Simultaneous: wrap plus en falling in the same cycle means en wins; there is no advance.
- Invariants:
  - At most one an_n bit is low at any time.
  - An an_n bit is low only when the matching sel bit is 1.
  - sel is always one-hot after the first clock following reset.
- Reset mid-dwell: all state returns to reset values immediately (asynchronously). The first dwell after release starts with sel=001 and no dead period.

Optional Feature:
SEG_SCAN_PWM_EN
- Defined:
  - Adds input port `duty` [3:0] and a free-running 4-bit pwm counter (reset 0, increments every clk when en=1).
  - The active anode is additionally gated, low only when pwm_cnt < duty.
  - duty=0 means fully dark; duty=15 gives 15/16 brightness.
  - Gating applies after dead-time and blank logic; the pwm counter holds while en=0.
- Undefined: no `duty` port and no pwm counter; the anode is fully on outside the dead time.

Decomposition:
- Shared include `seg_scan_defs.vh` holds the localparams SEL_D0=3'b001, SEL_D1=3'b010, SEL_D2=3'b100, AN_OFF=3'b111. The mux and this block share these encodings.
- One natural sub-module, `tick_gen`: parameterised prescaler with en input and registered wrap pulse. It is reused for debounce timing.

Test Plan:
- Reset release, CLK_DIV=8, DEAD_CYC=2, en=1, blank_in=000 -> sel=001 and an_n=110 from the first clock. tick pulses every 8 cycles; sel goes 010 then 100 then 001. an_n=111 for 2 cycles after each change, then ~sel.
- blank_in=010 held -> an_n stays 111 throughout every sel=010 dwell. The other digits are unaffected.
- en dropped mid-dwell at cnt=5 for 20 cycles -> sel holds, tick=0, an_n=111 from the next clock. After en=1, the next tick arrives 3 enabled cycles later.
- Force sel=011 via hierarchical deposit -> next clock sel=001, with an_n never having two bits low.
- rst_n asserted mid-dwell, asynchronously between clock edges -> outputs go to 001/111/0 immediately.
- With SEG_SCAN_PWM_EN, duty=4, CLK_DIV=64, DEAD_CYC=0 -> the active anode is low for exactly 4 of every 16 cycles. duty=0 gives an_n=111 throughout.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared digit-select / anode encodings and helpers for the seven-segment scan path.
// The segment mux imports the same constants so both sides agree on the one-hot order.
package seg_scan_ctrl_pkg;

  typedef logic [2:0] sel_t;

  localparam sel_t SEL_D0 = 3'b001;
  localparam sel_t SEL_D1 = 3'b010;
  localparam sel_t SEL_D2 = 3'b100;
  localparam sel_t AN_OFF = 3'b111;

  function automatic logic sel_is_onehot(input sel_t s);
    return (s == SEL_D0) || (s == SEL_D1) || (s == SEL_D2);
  endfunction

  // 001 -> 010 -> 100 -> 001
  function automatic sel_t sel_rotate(input sel_t s);
    return {s[1:0], s[2]};
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_tick_gen.sv
// Parameterised prescaler: counts enabled cycles and wraps at CLK_DIV-1.
// wrap is the combinational terminal-count strobe; tick is the same event registered.
module tick_gen #(
  parameter int CLK_DIV = 50000,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic wrap,
  output logic tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    wrap   = en && (cnt_q == CNT_W'(CLK_DIV - 1));
    cnt_d  = cnt_q;
    tick_d = wrap;
    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Three-digit seven-segment scan controller: rotating one-hot select, dead-timed anodes.
// Optional brightness PWM on the anodes when SEG_SCAN_PWM_EN is defined (adds `duty`).
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV  = 50000,
  parameter int CNT_W    = 16,
  parameter int DEAD_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] blank_in,
`ifdef SEG_SCAN_PWM_EN
  input  logic [3:0] duty,
`endif
  output logic [2:0] sel,
  output logic [2:0] an_n,
  output logic       tick
);

  logic             wrap;
  sel_t             sel_q, sel_d;
  sel_t             an_n_q, an_n_d;
  logic [CNT_W-1:0] dead_q, dead_d;
  logic [2:0]       gate;

  tick_gen #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .wrap  (wrap),
    .tick  (tick)
  );

`ifdef SEG_SCAN_PWM_EN
  logic [3:0] pwm_q, pwm_d;

  always_comb begin
    pwm_d = en ? pwm_q + 4'd1 : pwm_q;
    gate  = (pwm_q < duty) ? 3'b111 : 3'b000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= 4'd0;
    else        pwm_q <= pwm_d;
  end
`else
  assign gate = 3'b111;
`endif

  // Anodes are computed from the next select and next dead count so that both
  // registers update on the same edge and never disagree about the lit digit.
  always_comb begin
    sel_d  = sel_q;
    dead_d = dead_q;
    an_n_d = AN_OFF;
    if (!sel_is_onehot(sel_q)) begin
      sel_d = SEL_D0;
    end else if (wrap) begin
      sel_d = sel_rotate(sel_q);
    end
    if (en) begin
      if (sel_d != sel_q) begin
        dead_d = CNT_W'(DEAD_CYC);
      end else if (dead_q != '0) begin
        dead_d = dead_q - CNT_W'(1);
      end
      if (dead_d == '0) begin
        an_n_d = ~(sel_d & ~blank_in & gate);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= SEL_D0;
      an_n_q <= AN_OFF;
      dead_q <= '0;
    end else begin
      sel_q  <= sel_d;
      an_n_q <= an_n_d;
      dead_q <= dead_d;
    end
  end

  assign sel  = sel_q;
  assign an_n = an_n_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with CLK_DIV=8, DEAD_CYC=2; k counts enabled clocks since reset.
// Covers SEG_SCAN_PWM_EN when that macro is defined for the build.
module tb_seg_scan_ctrl;

  localparam int CLK_DIV  = 8;
  localparam int DEAD_CYC = 2;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] blank_in;
  logic [2:0] sel;
  logic [2:0] an_n;
  logic       tick;
`ifdef SEG_SCAN_PWM_EN
  logic [3:0] duty;
`endif

  int checks = 0;
  int errors = 0;
  int k      = 0;

  seg_scan_ctrl #(
    .CLK_DIV  (CLK_DIV),
    .CNT_W    (16),
    .DEAD_CYC (DEAD_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .blank_in (blank_in),
`ifdef SEG_SCAN_PWM_EN
    .duty     (duty),
`endif
    .sel      (sel),
    .an_n     (an_n),
    .tick     (tick)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d: observed %b expected %b", tag, k, obs, exp);
    end
  endtask

  task automatic chk_inv();
    logic [2:0] low;
    logic       ok;
    low = ~an_n;
    ok  = ($countones(low) <= 1) && ((low & ~sel) == 3'b000);
    chk("anode_invariant", {2'b00, ok}, 3'b001);
  endtask

  // expected behaviour, counted in enabled clocks since reset release
  function automatic logic [2:0] exp_sel(input int kk);
    case ((kk / CLK_DIV) % 3)
      0:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_an(input int kk);
    logic [2:0] g;
    g = 3'b111;
`ifdef SEG_SCAN_PWM_EN
    g = (((kk - 1) % 16) < int'(duty)) ? 3'b111 : 3'b000;
`endif
    if (kk >= CLK_DIV && (kk % CLK_DIV) < DEAD_CYC) return 3'b111;
    return ~(exp_sel(kk) & ~blank_in & g);
  endfunction

  function automatic logic [2:0] exp_tick(input int kk);
    return {2'b00, (kk >= CLK_DIV) && (kk % CLK_DIV == 0)};
  endfunction

  // driver tasks
  task automatic run_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      k++;
      chk("sel", sel, exp_sel(k));
      chk("an_n", an_n, exp_an(k));
      chk("tick", {2'b00, tick}, exp_tick(k));
      chk_inv();
    end
  endtask

  task automatic hold_check(input int n, input logic [2:0] es);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("hold_sel", sel, es);
      chk("hold_an_n", an_n, 3'b111);
      chk("hold_tick", {2'b00, tick}, 3'b000);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    blank_in = 3'b000;
`ifdef SEG_SCAN_PWM_EN
    duty     = 4'd15;
`endif
    repeat (2) @(negedge clk);
    chk("rst_sel", sel, 3'b001);
    chk("rst_an_n", an_n, 3'b111);
    chk("rst_tick", {2'b00, tick}, 3'b000);
    rst_n = 1'b1;
    k     = 0;

    // three full dwells, then blank digit 1 for the next three
    run_check(24);
    blank_in = 3'b010;
    run_check(29);

    // en low mid-dwell at cnt=5; tick arrives 3 enabled cycles after resume
    en = 1'b0;
    hold_check(20, 3'b001);
    en = 1'b1;
    run_check(3);
    blank_in = 3'b000;
    run_check(2);

    // upset on the select register: must recover to 001 on the next clock
    force dut.sel_q = 3'b011;
    #1;
    release dut.sel_q;
    #1;
    chk_inv();
    @(negedge clk);
    chk("seu_sel", sel, 3'b001);
    chk("seu_an_n", an_n, 3'b111);
    chk("seu_tick", {2'b00, tick}, 3'b000);
    chk_inv();

    // asynchronous reset between clock edges
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sel", sel, 3'b001);
    chk("async_rst_an_n", an_n, 3'b111);
    chk("async_rst_tick", {2'b00, tick}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    k     = 0;

    // en falls on the wrap cycle: no advance until re-enabled
    run_check(7);
    en = 1'b0;
    hold_check(3, 3'b001);
    en = 1'b1;
    run_check(3);

`ifdef SEG_SCAN_PWM_EN
    duty = 4'd4;
    run_check(16);
    duty = 4'd0;
    run_check(16);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
